zone_stat_accum: RTL and testbench

Per-zone luminance statistics stage for the zonal backlight path, placed directly downstream of `GrayScale`. Consumes the 8-bit gray pixel stream in raster order. Accumulates the sum and maximum of every backlight zone over a frame. Emits one result per zone (max and truncated mean) to the backlight level mapper, one zone per cycle, as each horizontal band of zones completes.

---
 rtl/zone_stat_accum.sv | 197 +++++++++++++++++++
 tb/tb_zone_stat_accum.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zone_stat_accum.sv
// zone_stat_accum: per-zone luminance statistics (max and truncated mean)
// over a raster gray stream. Zones are collected one horizontal band at a
// time. Each completed band is copied to a shadow bank and emitted one zone
// per cycle while the live bank keeps accumulating the next band.
module zone_stat_accum #(
    parameter int H_PIX   = 512,
    parameter int V_PIX   = 256,
    parameter int ZONES_X = 8,
    parameter int ZONES_Y = 4,
    localparam int IDX_W  = (ZONES_X * ZONES_Y > 1) ? $clog2(ZONES_X * ZONES_Y) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic             sof,
    input  logic [7:0]       gray,
    output logic             zone_valid,
    output logic [IDX_W-1:0] zone_idx,
    output logic [7:0]       zone_max,
    output logic [7:0]       zone_avg,
    output logic             frame_done,
    output logic             sync_err
);

    localparam int ZONE_W  = H_PIX / ZONES_X;
    localparam int ZONE_H  = V_PIX / ZONES_Y;
    localparam int ZW_LOG2 = $clog2(ZONE_W);
    localparam int ZH_LOG2 = $clog2(ZONE_H);
    localparam int SUM_W   = 8 + ZW_LOG2 + ZH_LOG2;
    localparam int XW      = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int YW      = (V_PIX > 1) ? $clog2(V_PIX) : 1;
    localparam int COL_W   = (ZONES_X > 1) ? $clog2(ZONES_X) : 1;
    localparam int BAND_W  = (ZONES_Y > 1) ? $clog2(ZONES_Y) : 1;

    localparam logic [IDX_W-1:0] ZX_I     = IDX_W'(ZONES_X);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ZONES_X * ZONES_Y - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(ZONES_X - 1);

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        RUN      = 1'b1
    } state_t;

    // Sum of 2^(ZW_LOG2+ZH_LOG2) pixels: dropping the low bits is the mean.
    function automatic logic [7:0] trunc_avg(input logic [SUM_W-1:0] s);
        return s[SUM_W-1 -: 8];
    endfunction

    function automatic logic [7:0] umax8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t state_q, state_d;
    logic   accept;

    logic [XW-1:0]     x_q, ex;
    logic [YW-1:0]     y_q, ey;
    logic              last_x, last_y, first_px, band_end, err_set;
    logic [COL_W-1:0]  col;
    logic [BAND_W-1:0] band_now;
    logic [SUM_W-1:0]  new_sum;
    logic [7:0]        new_max;
    logic [IDX_W-1:0]  base_now, idx_next;

    // p0: live bank, one entry per zone column of the current band
    logic [SUM_W-1:0] sum_p0 [ZONES_X];
    logic [7:0]       max_p0 [ZONES_X];
    logic [SUM_W-1:0] cap_sum [ZONES_X];
    logic [7:0]       cap_max [ZONES_X];

    // p1: shadow bank of the completed band being emitted
    logic [SUM_W-1:0]  sum_p1 [ZONES_X];
    logic [7:0]        max_p1 [ZONES_X];
    logic [BAND_W-1:0] band_p1;
    logic [COL_W-1:0]  emit_cnt;
    logic              emit_busy;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= WAIT_SOF;
        else        state_q <= state_d;
    end

    // Next state and pixel acceptance: sof always (re)starts a frame
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        if (pix_valid && sof) begin
            state_d = RUN;
            accept  = 1'b1;
        end else if (pix_valid && (state_q == RUN)) begin
            accept = 1'b1;
        end
    end

    // Effective pixel position, zone bookkeeping and band-end capture values
    always_comb begin
        ex       = sof ? '0 : x_q;
        ey       = sof ? '0 : y_q;
        last_x   = (ex == XW'(H_PIX - 1));
        last_y   = (ey == YW'(V_PIX - 1));
        col      = COL_W'(ex >> ZW_LOG2);
        first_px = ((ex & XW'(ZONE_W - 1)) == '0) && ((ey & YW'(ZONE_H - 1)) == '0);
        new_sum  = first_px ? SUM_W'(gray) : sum_p0[col] + SUM_W'(gray);
        new_max  = first_px ? gray : umax8(max_p0[col], gray);
        band_end = accept && last_x && ((ey & YW'(ZONE_H - 1)) == YW'(ZONE_H - 1));
        band_now = BAND_W'(ey >> ZH_LOG2);
        base_now = IDX_W'(band_now) * ZX_I;
        idx_next = IDX_W'(band_p1) * ZX_I + IDX_W'(emit_cnt);
        err_set  = pix_valid &&
                   ((sof && ((x_q != '0) || (y_q != '0))) ||
                    (!sof && (state_q == RUN) && (x_q == '0) && (y_q == '0)));
        for (int c = 0; c < ZONES_X; c++) begin
            cap_sum[c] = sum_p0[c];
            cap_max[c] = max_p0[c];
        end
        // The band-end pixel itself must be part of the captured band
        cap_sum[col] = new_sum;
        cap_max[col] = new_max;
    end

    // Raster counters and sticky sync error
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q      <= '0;
            y_q      <= '0;
            sync_err <= 1'b0;
        end else begin
            if (err_set) sync_err <= 1'b1;
            if (accept) begin
                if (last_x) begin
                    x_q <= '0;
                    y_q <= last_y ? '0 : ey + YW'(1);
                end else begin
                    x_q <= ex + XW'(1);
                    y_q <= ey;
                end
            end
        end
    end

    // Live bank: first pixel of a zone loads, later pixels accumulate
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < ZONES_X; c++) begin
                sum_p0[c] <= '0;
                max_p0[c] <= '0;
            end
        end else if (accept) begin
            sum_p0[col] <= new_sum;
            max_p0[col] <= new_max;
        end
    end

    // p1 -> p2: shadow capture at band end and one-zone-per-cycle emission
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < ZONES_X; c++) begin
                sum_p1[c] <= '0;
                max_p1[c] <= '0;
            end
            band_p1    <= '0;
            emit_cnt   <= '0;
            emit_busy  <= 1'b0;
            zone_valid <= 1'b0;
            zone_idx   <= '0;
            zone_max   <= '0;
            zone_avg   <= '0;
            frame_done <= 1'b0;
        end else begin
            zone_valid <= 1'b0;
            frame_done <= 1'b0;
            if (band_end) begin
                // Column 0 goes out straight from the capture values
                sum_p1     <= cap_sum;
                max_p1     <= cap_max;
                band_p1    <= band_now;
                emit_cnt   <= COL_W'(1);
                emit_busy  <= 1'b1;
                zone_valid <= 1'b1;
                zone_idx   <= base_now;
                zone_max   <= cap_max[0];
                zone_avg   <= trunc_avg(cap_sum[0]);
                frame_done <= (base_now == LAST_IDX);
            end else if (emit_busy) begin
                zone_valid <= 1'b1;
                zone_idx   <= idx_next;
                zone_max   <= max_p1[emit_cnt];
                zone_avg   <= trunc_avg(sum_p1[emit_cnt]);
                frame_done <= (idx_next == LAST_IDX);
                emit_cnt   <= emit_cnt + COL_W'(1);
                if (emit_cnt == LAST_COL) emit_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zone_stat_accum.sv
// Bench for zone_stat_accum on a 16x8 frame with 4x2 zones of 4x4 pixels.
module tb_zone_stat_accum;

    localparam int H    = 16;
    localparam int V    = 8;
    localparam int ZX   = 4;
    localparam int ZY   = 2;
    localparam int ZW   = H / ZX;
    localparam int ZH   = V / ZY;
    localparam int AREA = ZW * ZH;
    localparam int NZ   = ZX * ZY;

    logic       clk = 1'b0;
    logic       reset, pix_valid, sof;
    logic [7:0] gray;
    logic       zone_valid, frame_done, sync_err;
    logic [2:0] zone_idx;
    logic [7:0] zone_max, zone_avg;

    typedef struct {
        int idx;
        int mx;
        int av;
        bit fd;
        int cy;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   msum [NZ];
    int   mmax [NZ];

    zone_stat_accum #(.H_PIX(H), .V_PIX(V), .ZONES_X(ZX), .ZONES_Y(ZY)) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .sof(sof), .gray(gray),
        .zone_valid(zone_valid), .zone_idx(zone_idx), .zone_max(zone_max),
        .zone_avg(zone_avg), .frame_done(frame_done), .sync_err(sync_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pix_val(input int mode, input int val, input int x, input int y);
        case (mode)
            0:       return val;
            1:       return 16 * x;
            default: return (x == 5 && y == 6) ? 255 : 0;
        endcase
    endfunction

    task automatic drive_pixel(input bit v, input bit s, input int g);
        @(posedge clk);
        #1;
        pix_valid = v;
        sof       = s;
        gray      = 8'(g);
    endtask

    // Drives one full frame starting with sof; expected zones go to the scoreboard
    task automatic drive_frame(input int mode, input int val, input int gap);
        for (int z = 0; z < NZ; z++) begin
            msum[z] = 0;
            mmax[z] = 0;
        end
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                int g, z;
                g = pix_val(mode, val, x, y);
                drive_pixel(1'b1, (x == 0 && y == 0), g);
                z = (y / ZH) * ZX + x / ZW;
                msum[z] += g;
                if (g > mmax[z]) mmax[z] = g;
                if (x == H - 1 && (y % ZH) == ZH - 1) begin
                    for (int c = 0; c < ZX; c++) begin
                        int id;
                        id = (y / ZH) * ZX + c;
                        sbq.push_back('{id, mmax[id], msum[id] / AREA, (id == NZ - 1), cyc + 1 + c});
                    end
                end
                if (gap != 0) drive_pixel(1'b0, 1'b0, 0);
            end
        end
        drive_pixel(1'b0, 1'b0, 0);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d zone results still outstanding, required 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    // Scoreboard: every emitted zone is popped and compared against the model
    task automatic run_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            checks++;
            if (frame_done && !zone_valid) begin
                failures++;
                $display("FAIL frame_done_alone: frame_done=1 zone_valid=0 at cycle %0d, required 0", cyc);
            end
            if (zone_valid) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_zone: idx=%0d max=%0d avg=%0d at cycle %0d, required no output",
                             zone_idx, zone_max, zone_avg, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (zone_idx !== 3'(e.idx) || zone_max !== 8'(e.mx) || zone_avg !== 8'(e.av) ||
                        frame_done !== e.fd || cyc != e.cy) begin
                        failures++;
                        $display("FAIL zone_result: got idx=%0d max=%0d avg=%0d fd=%0b cyc=%0d, required idx=%0d max=%0d avg=%0d fd=%0b cyc=%0d",
                                 zone_idx, zone_max, zone_avg, frame_done, cyc, e.idx, e.mx, e.av, e.fd, e.cy);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({zone_valid, zone_idx, zone_max, zone_avg, frame_done, sync_err} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%0b idx=%0d max=%0d avg=%0d fd=%0b err=%0b, required all 0",
                     zone_valid, zone_idx, zone_max, zone_avg, frame_done, sync_err);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic check_err(input string name, input bit req);
        checks++;
        if (sync_err !== req) begin
            failures++;
            $display("FAIL %s: sync_err=%0b, required %0b", name, sync_err, req);
        end
    endtask

    task automatic test_uniform();
        drive_frame(0, 100, 0);
        wait_drain("uniform");
        check_err("uniform_sync_err", 1'b0);
    endtask

    task automatic test_ramp();
        drive_frame(1, 0, 0);
        wait_drain("ramp");
    endtask

    task automatic test_hot_pixel();
        drive_frame(2, 0, 0);
        wait_drain("hot_pixel");
    endtask

    task automatic test_gapped();
        drive_frame(0, 100, 1);
        wait_drain("gapped");
        check_err("gapped_sync_err", 1'b0);
    endtask

    task automatic test_back_to_back();
        drive_frame(0, 30, 0);
        drive_frame(1, 0, 0);
        wait_drain("back_to_back");
        check_err("back_to_back_sync_err", 1'b0);
    endtask

    task automatic test_early_sof();
        check_err("early_sof_before", 1'b0);
        for (int i = 0; i < 2 * H + 3; i++) drive_pixel(1'b1, (i == 0), 200);
        drive_frame(0, 50, 0);
        wait_drain("early_sof");
        check_err("early_sof_set", 1'b1);
        repeat (20) drive_pixel(1'b0, 1'b0, 0);
        check_err("early_sof_sticky", 1'b1);
    endtask

    task automatic test_reset_mid();
        int kc;
        int seen;
        for (int i = 0; i < ZH * H; i++) drive_pixel(1'b1, (i == 0), 120);
        kc = cyc;
        sbq.push_back('{0, 120, 120, 1'b0, kc + 1});
        sbq.push_back('{1, 120, 120, 1'b0, kc + 2});
        drive_pixel(1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({zone_valid, zone_idx, zone_max, zone_avg, frame_done} !== 21'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: valid=%0b idx=%0d max=%0d avg=%0d fd=%0b, required all 0",
                     zone_valid, zone_idx, zone_max, zone_avg, frame_done);
        end
        check_err("reset_mid_clears_err", 1'b0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (zone_valid) seen++;
        end
        for (int i = 0; i < ZH * H; i++) begin
            drive_pixel(1'b1, 1'b0, 255);
            @(negedge clk);
            if (zone_valid) seen++;
        end
        for (int i = 0; i < 10; i++) begin
            drive_pixel(1'b0, 1'b0, 0);
            @(negedge clk);
            if (zone_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_mid_dropped: %0d zone_valid cycles after reset, required 0", seen);
        end
        wait_drain("reset_mid_pre");
        drive_frame(0, 77, 0);
        wait_drain("reset_mid_restart");
        check_err("reset_mid_final_err", 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        pix_valid = 1'b0;
        sof       = 1'b0;
        gray      = 8'd0;
        fork
            run_monitor();
        join_none
        test_reset();
        test_uniform();
        test_ramp();
        test_hot_pixel();
        test_gapped();
        test_back_to_back();
        test_early_sof();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
